// File: rtl/mul_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply controller: data width, product
// field slices and the 2-bit FSM state encoding.
package mul_hilo_unit_pkg;

  localparam int WORD   = 32;
  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_SETTLE) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/mul_hilo_unit_reg32.sv
// 32-bit register with asynchronous active-high clear and a load enable.
// Used for the operand latches and the HI/LO result registers.
module reg32_en
  import mul_hilo_unit_pkg::*;
(
  input  logic            clock,
  input  logic            clear,
  input  logic            load,
  input  logic [WORD-1:0] d,
  output logic [WORD-1:0] q
);

  logic [WORD-1:0] q_q;
  logic [WORD-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) q_d = d;
  end

  // NOTE: sequential state is written only with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mul_hilo_unit.sv
// Multi-cycle controller and HI/LO result stage for an external combinational
// signed 32x32 multiplier; operands are held stable for SETTLE_CYCLES.
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2  // 1..15
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [WORD-1:0] op_a,
  input  logic [WORD-1:0] op_b,
  input  logic [63:0]     product,
  output logic [WORD-1:0] mul_x,
  output logic [WORD-1:0] mul_y,
  input  logic [WORD-1:0] bus_in,
  input  logic            hi_load,
  input  logic            lo_load,
  output logic [WORD-1:0] hi_out,
  output logic [WORD-1:0] lo_out,
  output logic            busy,
  output logic            done
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            op_load;
  logic            capture;
  logic            hi_en, lo_en;
  logic [WORD-1:0] hi_d, lo_d;

  assign op_load = (state_q == ST_IDLE) && start;
  assign capture = (state_q == ST_CAPTURE);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: only control state needs reset here; the data registers carry their
  // own clear inside reg32_en, so nothing downstream sees X after reset.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Product capture takes priority over a coincident bus write.
  always_comb begin
    hi_en = capture || hi_load;
    lo_en = capture || lo_load;
    hi_d  = bus_in;
    lo_d  = bus_in;
    if (capture) begin
      hi_d = product[HI_MSB:HI_LSB];
      lo_d = product[LO_MSB:LO_LSB];
    end
  end

  reg32_en u_mul_x (
    .clock (clock),
    .clear (clear),
    .load  (op_load),
    .d     (op_a),
    .q     (mul_x)
  );

  reg32_en u_mul_y (
    .clock (clock),
    .clear (clear),
    .load  (op_load),
    .d     (op_b),
    .q     (mul_y)
  );

  reg32_en u_hi (
    .clock (clock),
    .clear (clear),
    .load  (hi_en),
    .d     (hi_d),
    .q     (hi_out)
  );

  reg32_en u_lo (
    .clock (clock),
    .clear (clear),
    .load  (lo_en),
    .d     (lo_d),
    .q     (lo_out)
  );

  assign busy = is_busy(state_q);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit: three instances (SETTLE_CYCLES 1, 2, 15),
// each wired to its own behavioural signed multiplier.
module tb_mul_hilo_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start_v [0:2];
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] bus_in = '0;
  logic        hi_load = 1'b0;
  logic        lo_load = 1'b0;

  logic [31:0] mul_x_v [0:2];
  logic [31:0] mul_y_v [0:2];
  logic [63:0] prod_v  [0:2];
  logic [31:0] hi_v    [0:2];
  logic [31:0] lo_v    [0:2];
  logic        busy_v  [0:2];
  logic        done_v  [0:2];

  int settle_tab [0:2] = '{1, 2, 15};
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  // Behavioural multiplier: low 64 bits of the sign-extended operands.
  for (genvar g = 0; g < 3; g++) begin : g_mul
    assign prod_v[g] = {{32{mul_x_v[g][31]}}, mul_x_v[g]} *
                       {{32{mul_y_v[g][31]}}, mul_y_v[g]};
  end

  mul_hilo_unit #(.SETTLE_CYCLES(1)) dut_1 (
    .clock(clock), .clear(clear), .start(start_v[0]), .op_a(op_a), .op_b(op_b),
    .product(prod_v[0]), .mul_x(mul_x_v[0]), .mul_y(mul_y_v[0]), .bus_in(bus_in),
    .hi_load(hi_load), .lo_load(lo_load), .hi_out(hi_v[0]), .lo_out(lo_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  mul_hilo_unit #(.SETTLE_CYCLES(2)) dut_2 (
    .clock(clock), .clear(clear), .start(start_v[1]), .op_a(op_a), .op_b(op_b),
    .product(prod_v[1]), .mul_x(mul_x_v[1]), .mul_y(mul_y_v[1]), .bus_in(bus_in),
    .hi_load(hi_load), .lo_load(lo_load), .hi_out(hi_v[1]), .lo_out(lo_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  mul_hilo_unit #(.SETTLE_CYCLES(15)) dut_15 (
    .clock(clock), .clear(clear), .start(start_v[2]), .op_a(op_a), .op_b(op_b),
    .product(prod_v[2]), .mul_x(mul_x_v[2]), .mul_y(mul_y_v[2]), .bus_in(bus_in),
    .hi_load(hi_load), .lo_load(lo_load), .hi_out(hi_v[2]), .lo_out(lo_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full multiply on instance sel; HI/LO must land SETTLE+1 edges after E0.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string tag);
    int n;
    op_a = a;
    op_b = b;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    check({tag, ".busy"}, 64'(busy_v[sel]), 64'd1);
    n = 0;
    while (done_v[sel] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(settle_tab[sel] + 1));
    check({tag, ".hi"}, 64'(hi_v[sel]), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo_v[sel]), 64'(exp_lo));
    check({tag, ".busy_in_done"}, 64'(busy_v[sel]), 64'd0);
    tick();
    check({tag, ".done_one_cycle"}, 64'(done_v[sel]), 64'd0);
  endtask

  task automatic run_random(input int sel, input string tag);
    logic [31:0] a, b;
    longint      p;
    a = $urandom();
    b = $urandom();
    p = longint'($signed(a)) * longint'($signed(b));
    run_op(sel, a, b, p[63:32], p[31:0], tag);
  endtask

  initial begin
    int n;
    int pulses;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

    // Reset state
    tick();
    check("rst.mul_x", 64'(mul_x_v[1]), 64'd0);
    check("rst.mul_y", 64'(mul_y_v[1]), 64'd0);
    check("rst.hi", 64'(hi_v[1]), 64'd0);
    check("rst.lo", 64'(lo_v[1]), 64'd0);
    check("rst.busy", 64'(busy_v[1]), 64'd0);
    check("rst.done", 64'(done_v[1]), 64'd0);
    clear = 1'b0;
    tick();

    // Basic and boundary products
    run_op(1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "t1");
    run_op(1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "t2a");
    run_op(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, "t2b");

    // Restart during SETTLE and start during DONE are both ignored
    op_a = 32'd5;
    op_b = 32'd6;
    start_v[1] = 1'b1;
    tick();
    op_a = 32'd100;
    op_b = 32'hFFFF_FFFE;
    tick();
    start_v[1] = 1'b0;
    check("t3.mul_x_frozen", 64'(mul_x_v[1]), 64'd5);
    check("t3.mul_y_frozen", 64'(mul_y_v[1]), 64'd6);
    n = 1;
    while (done_v[1] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("t3.latency", 64'(n), 64'd3);
    check("t3.hi", 64'(hi_v[1]), 64'd0);
    check("t3.lo", 64'(lo_v[1]), 64'd30);
    op_a = 32'd9;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    check("t3.done_start_ignored", 64'(busy_v[1]), 64'd0);
    check("t3.done_single", 64'(done_v[1]), 64'd0);
    check("t3.mul_x_kept", 64'(mul_x_v[1]), 64'd5);

    // Bus writes: IDLE, dropped in CAPTURE, accepted in DONE, both at once
    bus_in = 32'hDEAD_BEEF;
    hi_load = 1'b1;
    tick();
    hi_load = 1'b0;
    check("t4.hi_load", 64'(hi_v[1]), 64'hDEAD_BEEF);
    check("t4.lo_unchanged", 64'(lo_v[1]), 64'd30);
    op_a = 32'd3;
    op_b = 32'd4;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    tick();
    check("t4.in_capture", 64'(busy_v[1]), 64'd1);
    bus_in = 32'h1234_5678;
    hi_load = 1'b1;
    tick();
    hi_load = 1'b0;
    check("t4.capture_wins_hi", 64'(hi_v[1]), 64'd0);
    check("t4.capture_lo", 64'(lo_v[1]), 64'd12);
    check("t4.done", 64'(done_v[1]), 64'd1);
    bus_in = 32'hCAFE_F00D;
    lo_load = 1'b1;
    tick();
    lo_load = 1'b0;
    check("t4.lo_load_in_done", 64'(lo_v[1]), 64'hCAFE_F00D);
    check("t4.hi_kept", 64'(hi_v[1]), 64'd0);
    bus_in = 32'hA5A5_5A5A;
    hi_load = 1'b1;
    lo_load = 1'b1;
    tick();
    hi_load = 1'b0;
    lo_load = 1'b0;
    check("t4.both_hi", 64'(hi_v[1]), 64'hA5A5_5A5A);
    check("t4.both_lo", 64'(lo_v[1]), 64'hA5A5_5A5A);

    // Asynchronous clear mid-SETTLE
    op_a = 32'd11;
    op_b = 32'd13;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    check("t5.mul_x", 64'(mul_x_v[1]), 64'd0);
    check("t5.hi", 64'(hi_v[1]), 64'd0);
    check("t5.lo", 64'(lo_v[1]), 64'd0);
    check("t5.busy", 64'(busy_v[1]), 64'd0);
    check("t5.done", 64'(done_v[1]), 64'd0);
    tick();
    clear = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_v[1] === 1'b1) pulses++;
    end
    check("t5.no_done", 64'(pulses), 64'd0);
    run_op(1, 32'd11, 32'd13, 32'd0, 32'd143, "t5.after");

    // SETTLE_CYCLES sweep and randomised operands
    run_op(0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "t6.s1");
    run_op(2, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "t6.s15");
    for (int i = 0; i < 4; i++) begin
      run_random(0, $sformatf("t6.r1_%0d", i));
      run_random(1, $sformatf("t6.r2_%0d", i));
      run_random(2, $sformatf("t6.r15_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
